// File: rtl/gray_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_counter: up/down binary counter with a registered Gray-coded copy,    |
// | terminal-count pulse and saturation flag.          Revision: 1.0           |
// +----------------------------------------------------------------------------+
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             sat
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_MAX  = '1;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;
  logic             r_sat;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_tc;
  logic             w_next_sat;
  logic             w_update;
  logic             w_at_limit;

  always_comb begin
    w_next_bin = r_bin;
    w_next_tc  = 1'b0;
    w_update   = 1'b0;
    if (load) begin
      w_next_bin = load_bin;
      w_update   = 1'b1;
    end else if (en) begin
      w_update = 1'b1;
      if (up_dn) begin
        if (r_bin == C_MAX) begin
          w_next_tc = 1'b1;
          if (WRAP) w_next_bin = C_ZERO;
        end else begin
          w_next_bin = r_bin + C_ONE;
        end
      end else begin
        if (r_bin == C_ZERO) begin
          w_next_tc = 1'b1;
          if (WRAP) w_next_bin = C_MAX;
        end else begin
          w_next_bin = r_bin - C_ONE;
        end
      end
    end
  end

  // Both code registers load from the same next value, so they never disagree.
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  assign w_at_limit  = (w_next_bin == C_ZERO) || (w_next_bin == C_MAX);
  assign w_next_sat  = w_update ? (!WRAP && w_at_limit) : r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= C_ZERO;
      r_gray <= C_ZERO;
      r_tc   <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_tc   <= w_next_tc;
      r_sat  <= w_next_sat;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign tc       = r_tc;
  assign sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gray_counter: directed and randomised checks of gray_counter with       |
// | WRAP=1 and WRAP=0 instances sharing one stimulus.  Revision: 1.0           |
// +----------------------------------------------------------------------------+
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_bin;

  logic [3:0] bw, gw, bs, gs;
  logic       tcw, satw, tcs, sats;

  int tests = 0;
  int fails = 0;

  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  // Reference state, index 0 = WRAP=1, index 1 = WRAP=0
  logic [3:0] mb   [2];
  logic       mtc  [2];
  logic       msat [2];

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
    .bin_out(bw), .gray_out(gw), .tc(tcw), .sat(satw)
  );

  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
    .bin_out(bs), .gray_out(gs), .tc(tcs), .sat(sats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input int i, input bit wrap);
    logic [3:0] nb;
    nb = mb[i];
    mtc[i] = 1'b0;
    if (load) begin
      nb = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (mb[i] == 4'd15) begin
          mtc[i] = 1'b1;
          if (wrap) nb = 4'd0;
        end else nb = mb[i] + 4'd1;
      end else begin
        if (mb[i] == 4'd0) begin
          mtc[i] = 1'b1;
          if (wrap) nb = 4'd15;
        end else nb = mb[i] - 4'd1;
      end
    end
    if (load || en) msat[i] = !wrap && (nb == 4'd0 || nb == 4'd15);
    mb[i] = nb;
  endtask

  initial begin
    logic [3:0] pg;
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'd0;
    #2;
    chk("rst_bin", bw, 0);
    chk("rst_gray", gw, 0);
    chk("rst_tc", tcw, 0);
    chk("rst_sat", sats, 0);

    // Count a little, then reset mid-stream for two cycles
    tick(); rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_bin", bw, 3);
    rst = 1'b1;
    tick(); tick();
    chk("mid_rst_bin", bw, 0);
    chk("mid_rst_gray", gw, 0);
    rst = 1'b0;

    pg = gw;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("up_bin", bw, k % 16);
      chk("up_gray", gw, gtab[k % 16]);
      chk("up_tc", tcw, (k == 16) ? 1 : 0);
      chk("up_hamming", $countones(pg ^ gw), 1);
      pg = gw;
    end

    // Down wrap from 0; WRAP=0 instance pins at 0
    load = 1'b1; load_bin = 4'd0; en = 1'b0;
    tick();
    chk("ld0_bin", bw, 0);
    chk("ld0_sat_s", sats, 1);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk("dn_bin0", bw, 15); chk("dn_gray0", gw, 4'b1000); chk("dn_tc0", tcw, 1);
    chk("dn_s_bin", bs, 0); chk("dn_s_tc", tcs, 1); chk("dn_s_sat", sats, 1);
    tick();
    chk("dn_bin1", bw, 14); chk("dn_gray1", gw, 4'b1001); chk("dn_tc1", tcw, 0);
    tick();
    chk("dn_bin2", bw, 13); chk("dn_gray2", gw, 4'b1011); chk("dn_tc2", tcw, 0);
    chk("dn_s_tc_rep", tcs, 1);

    // Load beats enable
    load = 1'b1; load_bin = 4'd9; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("ld9_bin", bw, 9); chk("ld9_gray", gw, 4'b1101); chk("ld9_tc", tcw, 0);
    load = 1'b0;
    tick();
    chk("ld9_next_bin", bw, 10); chk("ld9_next_gray", gw, 4'b1111);

    // Saturation at the top
    load = 1'b1; load_bin = 4'd14; en = 1'b0;
    tick();
    chk("ld14_sat", sats, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("sat_bin0", bs, 15); chk("sat_sat0", sats, 1); chk("sat_tc0", tcs, 0);
    chk("wrap_sat_tied", satw, 0);
    tick();
    chk("sat_bin1", bs, 15); chk("sat_tc1", tcs, 1); chk("sat_sat1", sats, 1);
    chk("sat_gray1", gs, 4'b1000);
    tick();
    chk("sat_bin2", bs, 15); chk("sat_tc2", tcs, 1);
    up_dn = 1'b0;
    tick();
    chk("unsat_bin", bs, 14); chk("unsat_sat", sats, 0); chk("unsat_tc", tcs, 0);

    // Hold, then asynchronous reset between edges
    load = 1'b1; load_bin = 4'd6;
    tick();
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_bin", bw, 6); chk("hold_gray", gw, 4'b0101); chk("hold_tc", tcw, 0);
    end
    #3;
    rst = 1'b1;
    #1;
    chk("async_bin", bw, 0); chk("async_gray", gw, 0);
    chk("async_bin_s", bs, 0); chk("async_gray_s", gs, 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mb[i] = 4'd0; mtc[i] = 1'b0; msat[i] = 1'b0;
    end

    // Randomised run against the reference model
    for (int n = 0; n < 1000; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1);
      load     = ($urandom_range(0, 9) == 0);
      load_bin = 4'($urandom_range(0, 15));
      pg = gw;
      tick();
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      chk("rnd_bin_w", bw, mb[0]);
      chk("rnd_gray_w", gw, mb[0] ^ (mb[0] >> 1));
      chk("rnd_tc_w", tcw, mtc[0]);
      chk("rnd_sat_w", satw, msat[0]);
      chk("rnd_bin_s", bs, mb[1]);
      chk("rnd_gray_s", gs, mb[1] ^ (mb[1] >> 1));
      chk("rnd_tc_s", tcs, mtc[1]);
      chk("rnd_sat_s", sats, msat[1]);
      if (!load && en) chk("rnd_hamming", $countones(pg ^ gw), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
